id_ex_operand_stage: RTL and testbench
======================================

ID_EX_OPERAND_STAGE -- requirements
Module: id_ex_operand_stage

Interface
REQ-001 SHALL have parameter DATA_W, default 32, datapath width.
REQ-002 SHALL have clk  input  1  rising-edge clock.
REQ-003 SHALL have reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have id_valid_i  input  1  decode presents an instruction.
REQ-005 SHALL have id_rs_addr_i, id_rt_addr_i, id_rd_addr_i  input  5 each  source and destination register numbers.
REQ-006 SHALL have id_rs_data_i, id_rt_data_i  input  DATA_W each  register-file read data.
REQ-007 SHALL have id_imm_i  input  DATA_W  extended immediate; id_shamt_i  input  5  shift amount.
REQ-008 SHALL have id_alu_op_i  input  4  ALU operation code.
REQ-009 SHALL have id_alu_src_i, id_reg_write_i, id_mem_read_i, id_mem_write_i, id_mem_to_reg_i  input  1 each  decode controls.
REQ-010 SHALL have flush_i  input  1  squash the instruction being captured.
REQ-011 SHALL have exm_reg_write_i  input  1, exm_rd_i  input  5, exm_data_i  input  DATA_W  EX/MEM forwarding source.
REQ-012 SHALL have wb_reg_write_i  input  1, wb_rd_i  input  5, wb_data_i  input  DATA_W  MEM/WB forwarding source.
REQ-013 SHALL have a_o, b_o  output  DATA_W each  ALU operands; shamt_o  output  5; alu_operation_o  output  4.
REQ-014 SHALL have store_data_o  output  DATA_W  forwarded rt value for stores; rd_o  output  5.
REQ-015 SHALL have valid_o, reg_write_o, mem_read_o, mem_write_o, mem_to_reg_o  output  1 each  registered controls.
REQ-016 SHALL have stall_o  output  1  load-use hazard; upstream holds PC and IF/ID while high.

Function
REQ-017 SHALL register all id_* inputs on each rising clk edge into one stage entry; latency exactly one cycle.
REQ-018 SHALL compute stall_o combinationally = valid_q & mem_read_q & id_valid_i & rd_q!=0 & (rd_q==id_rs_addr_i | rd_q==id_rt_addr_i).
REQ-019 SHALL, when stall_o=1 or flush_i=1, capture a bubble: valid, reg_write, mem_read, mem_write, mem_to_reg all 0; data fields don't-care.
REQ-020 SHALL give flush_i priority over stall; both high -> single bubble, stall_o still reflects the REQ-018 equation.
REQ-021 SHALL capture id_valid_i=0 as a bubble identical to REQ-019.
REQ-022 SHALL forward per operand (rs, rt): EX/MEM if exm_reg_write_i & exm_rd_i!=0 & exm_rd_i==addr; else MEM/WB if wb_reg_write_i & wb_rd_i!=0 & wb_rd_i==addr; else registered data.
REQ-023 SHALL give EX/MEM priority over MEM/WB when both match the same register.
REQ-024 SHALL never forward to register 0; operand from register 0 is always the registered value.
REQ-025 SHALL drive a_o = forwarded rs; b_o = id_imm registered if alu_src_q=1 else forwarded rt; store_data_o = forwarded rt always.
REQ-026 SHALL drive forwarding combinationally from current-cycle exm/wb inputs (no extra latency).
REQ-027 SHALL pass shamt_o, alu_operation_o, rd_o unchanged from registered values; op codes not interpreted here.

Reset
REQ-028 SHALL on reset clear every stage register to 0 asynchronously: valid_o, all controls, a/b sources, shamt_o, alu_operation_o (0000), rd_o = 0.
REQ-029 SHALL, with reset asserted mid-stall, force stall_o=0 (valid_q=0) and resume capture on the first clk edge after deassertion.

Structure
REQ-030 SHALL take ALU op codes (ADD 0011, LUI 0000, OR 0001, SLL 0010, SRL 0100) and forward-select enum (FWD_REG, FWD_EXM, FWD_WB) from shared package mips_pkg.
REQ-031 SHALL instantiate one sub-module forward_unit (one instance per operand) implementing REQ-022..REQ-024.

Verification
REQ-032 SHALL test capture: rs=8 data 0x5, rt=9 data 0x7, alu_op ADD, alu_src=0 -> next cycle a_o=0x5, b_o=0x7, valid_o=1.
REQ-033 SHALL test forwarding priority: captured rs=3, exm_rd=3 data 0xAAAA, wb_rd=3 data 0xBBBB, both writes -> a_o=0xAAAA; drop exm_reg_write -> a_o=0xBBBB.
REQ-034 SHALL test register 0: captured rt=0, exm_rd=0 data 0xFFFF_FFFF, exm_reg_write=1 -> b_o=registered 0.
REQ-035 SHALL test load-use: lw to rd=4 in stage, decode rs=4 -> stall_o=1, next cycle valid_o=0, mem_read_o=0; then stall_o=0.
REQ-036 SHALL test flush+stall together -> one bubble; and reset asserted during stall -> all outputs 0 immediately, stall_o=0.
REQ-037 SHALL test alu_src=1, imm 0x0000_1234, alu_op LUI -> b_o=0x0000_1234, store_data_o=forwarded rt.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions.
// Contents:
//   alu_op_e  - ALU operation codes carried through ID/EX uninterpreted
//   fwd_sel_e - operand source selected by the forwarding logic
//   fwd_hit   - match test for one forwarding source
package mips_pkg;

  localparam int REG_ADDR_W = 5;

  typedef enum logic [3:0] {
    ALU_LUI = 4'b0000,
    ALU_OR  = 4'b0001,
    ALU_SLL = 4'b0010,
    ALU_ADD = 4'b0011,
    ALU_SRL = 4'b0100
  } alu_op_e;

  typedef enum logic [1:0] {
    FWD_REG = 2'd0,
    FWD_EXM = 2'd1,
    FWD_WB  = 2'd2
  } fwd_sel_e;

  // A source forwards only when it writes a nonzero register equal to the
  // operand's register; register 0 is hardwired and never forwarded.
  function automatic logic fwd_hit(input logic                  we,
                                   input logic [REG_ADDR_W-1:0] src_rd,
                                   input logic [REG_ADDR_W-1:0] addr);
    return we & (src_rd != 5'd0) & (src_rd == addr);
  endfunction

endpackage

// File: rtl/id_ex_operand_stage_forward_unit.sv
// forward_unit: selects the value of one ALU source operand.
// Ports:
//   addr_i          - register number of the operand
//   reg_data_i      - value read from the register file (registered in ID/EX)
//   exm_reg_write_i, exm_rd_i, exm_data_i - EX/MEM result source
//   wb_reg_write_i,  wb_rd_i,  wb_data_i  - MEM/WB result source
//   data_o          - forwarded operand value
module forward_unit
  import mips_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [4:0]        addr_i,
  input  logic [DATA_W-1:0] reg_data_i,
  input  logic              exm_reg_write_i,
  input  logic [4:0]        exm_rd_i,
  input  logic [DATA_W-1:0] exm_data_i,
  input  logic              wb_reg_write_i,
  input  logic [4:0]        wb_rd_i,
  input  logic [DATA_W-1:0] wb_data_i,
  output logic [DATA_W-1:0] data_o
);

  fwd_sel_e fwd_sel;

  // Source selection: the younger EX/MEM result wins over MEM/WB.
  always_comb begin
    fwd_sel = FWD_REG;
    if (fwd_hit(exm_reg_write_i, exm_rd_i, addr_i)) begin
      fwd_sel = FWD_EXM;
    end else if (fwd_hit(wb_reg_write_i, wb_rd_i, addr_i)) begin
      fwd_sel = FWD_WB;
    end else begin
      fwd_sel = FWD_REG;
    end
  end

  // Operand mux driven by the selection above.
  always_comb begin
    data_o = reg_data_i;
    case (fwd_sel)
      FWD_EXM: data_o = exm_data_i;
      FWD_WB:  data_o = wb_data_i;
      FWD_REG: data_o = reg_data_i;
      default: data_o = reg_data_i;
    endcase
  end

endmodule

// File: rtl/id_ex_operand_stage.sv
// id_ex_operand_stage: ID/EX pipeline register with operand forwarding and
// load-use hazard detection.
// Ports:
//   clk, reset            - rising-edge clock, asynchronous active-high reset
//   id_*_i                - decoded instruction fields captured each cycle
//   flush_i               - squash the instruction being captured
//   exm_*_i / wb_*_i      - EX/MEM and MEM/WB forwarding sources
//   a_o, b_o              - ALU operands (b_o is the immediate when alu_src)
//   store_data_o          - forwarded rt value for stores
//   shamt_o, alu_operation_o, rd_o - registered pass-through fields
//   valid_o, reg_write_o, mem_read_o, mem_write_o, mem_to_reg_o - controls
//   stall_o               - load-use hazard; upstream holds PC and IF/ID
module id_ex_operand_stage
  import mips_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid_i,
  input  logic [4:0]        id_rs_addr_i,
  input  logic [4:0]        id_rt_addr_i,
  input  logic [4:0]        id_rd_addr_i,
  input  logic [DATA_W-1:0] id_rs_data_i,
  input  logic [DATA_W-1:0] id_rt_data_i,
  input  logic [DATA_W-1:0] id_imm_i,
  input  logic [4:0]        id_shamt_i,
  input  logic [3:0]        id_alu_op_i,
  input  logic              id_alu_src_i,
  input  logic              id_reg_write_i,
  input  logic              id_mem_read_i,
  input  logic              id_mem_write_i,
  input  logic              id_mem_to_reg_i,
  input  logic              flush_i,
  input  logic              exm_reg_write_i,
  input  logic [4:0]        exm_rd_i,
  input  logic [DATA_W-1:0] exm_data_i,
  input  logic              wb_reg_write_i,
  input  logic [4:0]        wb_rd_i,
  input  logic [DATA_W-1:0] wb_data_i,
  output logic [DATA_W-1:0] a_o,
  output logic [DATA_W-1:0] b_o,
  output logic [4:0]        shamt_o,
  output logic [3:0]        alu_operation_o,
  output logic [DATA_W-1:0] store_data_o,
  output logic [4:0]        rd_o,
  output logic              valid_o,
  output logic              reg_write_o,
  output logic              mem_read_o,
  output logic              mem_write_o,
  output logic              mem_to_reg_o,
  output logic              stall_o
);

  // Control registers (zeroed for a bubble)
  logic valid_q, valid_d;
  logic reg_write_q, reg_write_d;
  logic mem_read_q, mem_read_d;
  logic mem_write_q, mem_write_d;
  logic mem_to_reg_q, mem_to_reg_d;

  // Data registers (don't-care in a bubble, captured unconditionally)
  logic              alu_src_q;
  logic [4:0]        rs_addr_q, rt_addr_q, rd_q, shamt_q;
  logic [3:0]        alu_op_q;
  logic [DATA_W-1:0] rs_data_q, rt_data_q, imm_q;

  logic              stall_s;
  logic              capture_s;
  logic [DATA_W-1:0] rs_fwd_s, rt_fwd_s;

  // Load-use hazard: a load in this stage feeds a source of the decoding
  // instruction, so one bubble must be inserted before it can advance.
  always_comb begin
    stall_s = valid_q & mem_read_q & id_valid_i & (rd_q != 5'd0) &
              ((rd_q == id_rs_addr_i) | (rd_q == id_rt_addr_i));
  end

  // Control next-state: flush, stall and an invalid decode all give a bubble.
  always_comb begin
    capture_s    = id_valid_i & ~flush_i & ~stall_s;
    valid_d      = 1'b0;
    reg_write_d  = 1'b0;
    mem_read_d   = 1'b0;
    mem_write_d  = 1'b0;
    mem_to_reg_d = 1'b0;
    if (capture_s) begin
      valid_d      = 1'b1;
      reg_write_d  = id_reg_write_i;
      mem_read_d   = id_mem_read_i;
      mem_write_d  = id_mem_write_i;
      mem_to_reg_d = id_mem_to_reg_i;
    end else begin
      valid_d      = 1'b0;
      reg_write_d  = 1'b0;
      mem_read_d   = 1'b0;
      mem_write_d  = 1'b0;
      mem_to_reg_d = 1'b0;
    end
  end

  // Stage register; everything clears asynchronously on reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q      <= 1'b0;
      reg_write_q  <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
      alu_src_q    <= 1'b0;
      rs_addr_q    <= 5'd0;
      rt_addr_q    <= 5'd0;
      rd_q         <= 5'd0;
      shamt_q      <= 5'd0;
      alu_op_q     <= ALU_LUI;
      rs_data_q    <= {DATA_W{1'b0}};
      rt_data_q    <= {DATA_W{1'b0}};
      imm_q        <= {DATA_W{1'b0}};
    end else begin
      valid_q      <= valid_d;
      reg_write_q  <= reg_write_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      mem_to_reg_q <= mem_to_reg_d;
      alu_src_q    <= id_alu_src_i;
      rs_addr_q    <= id_rs_addr_i;
      rt_addr_q    <= id_rt_addr_i;
      rd_q         <= id_rd_addr_i;
      shamt_q      <= id_shamt_i;
      alu_op_q     <= id_alu_op_i;
      rs_data_q    <= id_rs_data_i;
      rt_data_q    <= id_rt_data_i;
      imm_q        <= id_imm_i;
    end
  end

  forward_unit #(.DATA_W(DATA_W)) u_fwd_rs (
    .addr_i          (rs_addr_q),
    .reg_data_i      (rs_data_q),
    .exm_reg_write_i (exm_reg_write_i),
    .exm_rd_i        (exm_rd_i),
    .exm_data_i      (exm_data_i),
    .wb_reg_write_i  (wb_reg_write_i),
    .wb_rd_i         (wb_rd_i),
    .wb_data_i       (wb_data_i),
    .data_o          (rs_fwd_s)
  );

  forward_unit #(.DATA_W(DATA_W)) u_fwd_rt (
    .addr_i          (rt_addr_q),
    .reg_data_i      (rt_data_q),
    .exm_reg_write_i (exm_reg_write_i),
    .exm_rd_i        (exm_rd_i),
    .exm_data_i      (exm_data_i),
    .wb_reg_write_i  (wb_reg_write_i),
    .wb_rd_i         (wb_rd_i),
    .wb_data_i       (wb_data_i),
    .data_o          (rt_fwd_s)
  );

  // Operand B takes the immediate for alu_src; stores always use forwarded rt.
  always_comb begin
    a_o          = rs_fwd_s;
    store_data_o = rt_fwd_s;
    if (alu_src_q) begin
      b_o = imm_q;
    end else begin
      b_o = rt_fwd_s;
    end
  end

  assign stall_o         = stall_s;
  assign shamt_o         = shamt_q;
  assign alu_operation_o = alu_op_q;
  assign rd_o            = rd_q;
  assign valid_o         = valid_q;
  assign reg_write_o     = reg_write_q;
  assign mem_read_o      = mem_read_q;
  assign mem_write_o     = mem_write_q;
  assign mem_to_reg_o    = mem_to_reg_q;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Directed self-checking bench for id_ex_operand_stage.
module tb_id_ex_operand_stage;

  logic        clk;
  logic        reset;
  logic        id_valid_i;
  logic [4:0]  id_rs_addr_i, id_rt_addr_i, id_rd_addr_i, id_shamt_i;
  logic [31:0] id_rs_data_i, id_rt_data_i, id_imm_i;
  logic [3:0]  id_alu_op_i;
  logic        id_alu_src_i, id_reg_write_i, id_mem_read_i, id_mem_write_i, id_mem_to_reg_i;
  logic        flush_i;
  logic        exm_reg_write_i, wb_reg_write_i;
  logic [4:0]  exm_rd_i, wb_rd_i;
  logic [31:0] exm_data_i, wb_data_i;
  logic [31:0] a_o, b_o, store_data_o;
  logic [4:0]  shamt_o, rd_o;
  logic [3:0]  alu_operation_o;
  logic        valid_o, reg_write_o, mem_read_o, mem_write_o, mem_to_reg_o, stall_o;

  int n_tests = 0;
  int n_fail  = 0;

  id_ex_operand_stage #(.DATA_W(32)) dut (
    .clk(clk), .reset(reset), .id_valid_i(id_valid_i),
    .id_rs_addr_i(id_rs_addr_i), .id_rt_addr_i(id_rt_addr_i), .id_rd_addr_i(id_rd_addr_i),
    .id_rs_data_i(id_rs_data_i), .id_rt_data_i(id_rt_data_i), .id_imm_i(id_imm_i),
    .id_shamt_i(id_shamt_i), .id_alu_op_i(id_alu_op_i), .id_alu_src_i(id_alu_src_i),
    .id_reg_write_i(id_reg_write_i), .id_mem_read_i(id_mem_read_i),
    .id_mem_write_i(id_mem_write_i), .id_mem_to_reg_i(id_mem_to_reg_i),
    .flush_i(flush_i),
    .exm_reg_write_i(exm_reg_write_i), .exm_rd_i(exm_rd_i), .exm_data_i(exm_data_i),
    .wb_reg_write_i(wb_reg_write_i), .wb_rd_i(wb_rd_i), .wb_data_i(wb_data_i),
    .a_o(a_o), .b_o(b_o), .shamt_o(shamt_o), .alu_operation_o(alu_operation_o),
    .store_data_o(store_data_o), .rd_o(rd_o), .valid_o(valid_o),
    .reg_write_o(reg_write_o), .mem_read_o(mem_read_o), .mem_write_o(mem_write_o),
    .mem_to_reg_o(mem_to_reg_o), .stall_o(stall_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Safety net so the run can never hang.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_instr(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                           input logic [4:0] rd, input logic [31:0] rsd, input logic [31:0] rtd,
                           input logic [31:0] imm, input logic [4:0] sh, input logic [3:0] op,
                           input logic asrc, input logic rw, input logic mr, input logic mw,
                           input logic m2r);
    id_valid_i = v;  id_rs_addr_i = rs; id_rt_addr_i = rt; id_rd_addr_i = rd;
    id_rs_data_i = rsd; id_rt_data_i = rtd; id_imm_i = imm; id_shamt_i = sh;
    id_alu_op_i = op; id_alu_src_i = asrc; id_reg_write_i = rw;
    id_mem_read_i = mr; id_mem_write_i = mw; id_mem_to_reg_i = m2r;
  endtask

  task automatic clear_fwd();
    exm_reg_write_i = 1'b0; exm_rd_i = 5'd0; exm_data_i = 32'd0;
    wb_reg_write_i  = 1'b0; wb_rd_i  = 5'd0; wb_data_i  = 32'd0;
  endtask

  initial begin
    reset = 1'b1;
    flush_i = 1'b0;
    clear_fwd();
    set_instr(1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 5'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    #2;
    check("rst_valid", 32'(valid_o), 32'd0);
    check("rst_a", a_o, 32'd0);
    check("rst_b", b_o, 32'd0);
    check("rst_aluop", 32'(alu_operation_o), 32'd0);
    check("rst_rd", 32'(rd_o), 32'd0);
    check("rst_stall", 32'(stall_o), 32'd0);
    tick();
    reset = 1'b0;

    // Basic capture: ADD r10 = r8 + r9
    set_instr(1'b1, 5'd8, 5'd9, 5'd10, 32'h5, 32'h7, 32'h0, 5'd7, 4'b0011, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    #1;
    check("cap_latency_valid", 32'(valid_o), 32'd0);
    tick();
    check("cap_a", a_o, 32'h5);
    check("cap_b", b_o, 32'h7);
    check("cap_valid", 32'(valid_o), 32'd1);
    check("cap_regw", 32'(reg_write_o), 32'd1);
    check("cap_aluop", 32'(alu_operation_o), 32'h3);
    check("cap_rd", 32'(rd_o), 32'd10);
    check("cap_shamt", 32'(shamt_o), 32'd7);
    check("cap_store", store_data_o, 32'h7);

    // Forwarding priority on rs=3, plus MEM/WB forwarding on rt=5
    set_instr(1'b1, 5'd3, 5'd5, 5'd6, 32'h11, 32'h22, 32'h0, 5'd0, 4'b0001, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    set_instr(1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 5'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    exm_reg_write_i = 1'b1; exm_rd_i = 5'd3; exm_data_i = 32'hAAAA;
    wb_reg_write_i  = 1'b1; wb_rd_i  = 5'd3; wb_data_i  = 32'hBBBB;
    #1;
    check("fwd_both_a", a_o, 32'hAAAA);
    check("fwd_both_b", b_o, 32'h22);
    exm_reg_write_i = 1'b0;
    #1;
    check("fwd_wb_a", a_o, 32'hBBBB);
    wb_reg_write_i = 1'b0;
    #1;
    check("fwd_none_a", a_o, 32'h11);
    wb_reg_write_i = 1'b1; wb_rd_i = 5'd5; wb_data_i = 32'hCCCC;
    #1;
    check("fwd_wb_b", b_o, 32'hCCCC);
    check("fwd_wb_store", store_data_o, 32'hCCCC);
    clear_fwd();

    // Register 0 never forwarded
    set_instr(1'b1, 5'd1, 5'd0, 5'd2, 32'h1, 32'h0, 32'h0, 5'd0, 4'b0011, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    exm_reg_write_i = 1'b1; exm_rd_i = 5'd0; exm_data_i = 32'hFFFF_FFFF;
    wb_reg_write_i  = 1'b1; wb_rd_i  = 5'd0; wb_data_i  = 32'hDEAD;
    #1;
    check("r0_b", b_o, 32'h0);
    check("r0_store", store_data_o, 32'h0);
    check("r0_a", a_o, 32'h1);
    clear_fwd();

    // Invalid decode becomes a bubble
    set_instr(1'b0, 5'd1, 5'd2, 5'd3, 32'h1, 32'h2, 32'h0, 5'd0, 4'b0011, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    check("inv_valid", 32'(valid_o), 32'd0);
    check("inv_regw", 32'(reg_write_o), 32'd0);
    check("inv_memw", 32'(mem_write_o), 32'd0);

    // Load-use: lw r4, 8(r2) followed by use of r4
    set_instr(1'b1, 5'd2, 5'd0, 5'd4, 32'h100, 32'h0, 32'h8, 5'd0, 4'b0011, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    tick();
    check("lw_memr", 32'(mem_read_o), 32'd1);
    check("lw_m2r", 32'(mem_to_reg_o), 32'd1);
    check("lw_b_imm", b_o, 32'h8);
    set_instr(1'b1, 5'd4, 5'd6, 5'd7, 32'h44, 32'h66, 32'h0, 5'd0, 4'b0011, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    #1;
    check("lu_stall", 32'(stall_o), 32'd1);
    tick();
    check("lu_bub_valid", 32'(valid_o), 32'd0);
    check("lu_bub_memr", 32'(mem_read_o), 32'd0);
    check("lu_bub_regw", 32'(reg_write_o), 32'd0);
    check("lu_stall_drop", 32'(stall_o), 32'd0);
    tick();
    check("lu_resume_valid", 32'(valid_o), 32'd1);
    check("lu_resume_rd", 32'(rd_o), 32'd7);
    check("lu_resume_a", a_o, 32'h44);

    // Load to r0 never stalls
    set_instr(1'b1, 5'd2, 5'd0, 5'd0, 32'h100, 32'h0, 32'h8, 5'd0, 4'b0011, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    tick();
    set_instr(1'b1, 5'd0, 5'd0, 5'd7, 32'h0, 32'h0, 32'h0, 5'd0, 4'b0011, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    #1;
    check("lu_r0_nostall", 32'(stall_o), 32'd0);

    // Load-use through rt
    set_instr(1'b1, 5'd2, 5'd0, 5'd9, 32'h100, 32'h0, 32'h8, 5'd0, 4'b0011, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    tick();
    set_instr(1'b1, 5'd1, 5'd9, 5'd7, 32'h0, 32'h0, 32'h0, 5'd0, 4'b0011, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    #1;
    check("lu_rt_stall", 32'(stall_o), 32'd1);

    // Flush alone squashes a store
    set_instr(1'b1, 5'd1, 5'd2, 5'd0, 32'h0, 32'h0, 32'h4, 5'd0, 4'b0011, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    check("flush_valid", 32'(valid_o), 32'd0);
    check("flush_memw", 32'(mem_write_o), 32'd0);

    // Flush and stall together: exactly one bubble
    set_instr(1'b1, 5'd2, 5'd0, 5'd4, 32'h100, 32'h0, 32'h8, 5'd0, 4'b0011, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    tick();
    set_instr(1'b1, 5'd4, 5'd6, 5'd7, 32'h44, 32'h66, 32'h0, 5'd0, 4'b0011, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    flush_i = 1'b1;
    #1;
    check("fs_stall", 32'(stall_o), 32'd1);
    tick();
    flush_i = 1'b0;
    check("fs_bub_valid", 32'(valid_o), 32'd0);
    check("fs_bub_memr", 32'(mem_read_o), 32'd0);
    check("fs_stall_drop", 32'(stall_o), 32'd0);
    tick();
    check("fs_single_bubble", 32'(valid_o), 32'd1);

    // Reset asserted while stalled
    set_instr(1'b1, 5'd2, 5'd0, 5'd4, 32'h100, 32'h0, 32'h8, 5'd3, 4'b0011, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    tick();
    set_instr(1'b1, 5'd4, 5'd6, 5'd7, 32'h44, 32'h66, 32'h0, 5'd0, 4'b0001, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    #1;
    check("rs_pre_stall", 32'(stall_o), 32'd1);
    reset = 1'b1;
    #1;
    check("rs_stall", 32'(stall_o), 32'd0);
    check("rs_valid", 32'(valid_o), 32'd0);
    check("rs_memr", 32'(mem_read_o), 32'd0);
    check("rs_a", a_o, 32'h0);
    check("rs_b", b_o, 32'h0);
    check("rs_store", store_data_o, 32'h0);
    check("rs_rd", 32'(rd_o), 32'd0);
    check("rs_shamt", 32'(shamt_o), 32'd0);
    tick();
    check("rs_hold_valid", 32'(valid_o), 32'd0);
    reset = 1'b0;
    tick();
    check("rs_resume_valid", 32'(valid_o), 32'd1);
    check("rs_resume_rd", 32'(rd_o), 32'd7);
    check("rs_resume_aluop", 32'(alu_operation_o), 32'h1);

    // LUI with immediate operand
    set_instr(1'b1, 5'd0, 5'd9, 5'd11, 32'h0, 32'h77, 32'h0000_1234, 5'd0, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    check("lui_b", b_o, 32'h0000_1234);
    check("lui_store", store_data_o, 32'h77);
    check("lui_aluop", 32'(alu_operation_o), 32'h0);
    exm_reg_write_i = 1'b1; exm_rd_i = 5'd9; exm_data_i = 32'h5555;
    #1;
    check("lui_store_fwd", store_data_o, 32'h5555);
    check("lui_b_fwd", b_o, 32'h0000_1234);
    clear_fwd();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
